// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared vending constants: FSM state encoding and money width
//
// Purpose: state encodings and the coin-count width used by change_dispenser
// and the vending controller that drives it.
// Ports: none (package).
package vending_pkg;

    localparam int MONEY_W_DEF = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EJECT = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

endpackage

// File: rtl/dly_counter.sv
// rtl/dly_counter.sv - loadable saturating down-counter with zero flag
//
// Purpose: shared delay timer; loaded with N-1 it flags zero after N cycles
// of decrement enable.
// Ports:
//   Clock       in  1      clock, posedge
//   Reset       in  1      synchronous active-high clear
//   load_i      in  1      load load_val_i (priority over dec_i)
//   load_val_i  in  CNT_W  value to load
//   dec_i       in  1      decrement by one, holds at zero
//   zero_o      out 1      count is zero
module dly_counter #(
    parameter int CNT_W = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays a latched money balance out one coin at a time
//
// Purpose: on a Change strobe latch Money and request coins from the ejector
// over a Coin_Out/Coin_Ack handshake, with an inter-coin gap and an ack
// timeout that parks the FSM in a sticky FAULT state until retried.
// Ports:
//   Clock      in  1        clock, posedge
//   Reset      in  1        synchronous active-high reset
//   Change     in  1        one-cycle change-request strobe
//   Money      in  MONEY_W  balance, sampled when Change is accepted in IDLE
//   Coin_Ack   in  1        ejector released one coin (level)
//   Coin_Out   out 1        coin request, high while waiting for an ack
//   Busy       out 1        high from accept through the Done cycle
//   Remaining  out MONEY_W  coins still to pay
//   Done       out 1        one-cycle pulse when payout completes
//   Fault      out 1        ejector timeout flag (until retry or reset)
module change_dispenser
    import vending_pkg::*;
#(
    parameter int MONEY_W     = MONEY_W_DEF,
    parameter int GAP_CYC     = 3,
    parameter int ACK_TIMEOUT = 50
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Change,
    input  logic [MONEY_W-1:0] Money,
    input  logic               Coin_Ack,
    output logic               Coin_Out,
    output logic               Busy,
    output logic [MONEY_W-1:0] Remaining,
    output logic               Done,
    output logic               Fault
);

    localparam int CNT_MAX = (GAP_CYC > ACK_TIMEOUT) ? GAP_CYC : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Timer is loaded with N-1 so that its zero flag marks the Nth cycle.
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [MONEY_W-1:0] remaining_q;
    logic [MONEY_W-1:0] remaining_d;
    logic [MONEY_W-1:0] remaining_dec;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic               tmr_dec;
    logic               tmr_zero;

    dly_counter #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Saturating decrement: Remaining never wraps below zero.
    assign remaining_dec = (remaining_q != '0) ? (remaining_q - MONEY_W'(1)) : '0;

    // State and Remaining registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state, Remaining update and timer control.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Change) begin
                    if (Money != '0) begin
                        state_d      = ST_EJECT;
                        remaining_d  = Money;
                        tmr_load     = 1'b1;
                        tmr_load_val = ACK_LOAD;
                    end else begin
                        state_d     = ST_DONE;
                        remaining_d = '0;
                    end
                end
            end

            ST_EJECT: begin
                // An ack in the same cycle as the timeout still counts.
                if (Coin_Ack) begin
                    remaining_d = remaining_dec;
                    if (remaining_dec != '0) begin
                        state_d      = ST_GAP;
                        tmr_load     = 1'b1;
                        tmr_load_val = GAP_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (tmr_zero) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_GAP: begin
                if (tmr_zero) begin
                    state_d      = ST_EJECT;
                    tmr_load     = 1'b1;
                    tmr_load_val = ACK_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end

            ST_FAULT: begin
                // Retry keeps the unpaid count; Money is not resampled.
                if (Change) begin
                    state_d      = ST_EJECT;
                    tmr_load     = 1'b1;
                    tmr_load_val = ACK_LOAD;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        Coin_Out  = (state_q == ST_EJECT);
        Busy      = (state_q != ST_IDLE);
        Done      = (state_q == ST_DONE);
        Fault     = (state_q == ST_FAULT);
        Remaining = remaining_q;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    localparam int MONEY_W     = 5;
    localparam int GAP_CYC     = 3;
    localparam int ACK_TIMEOUT = 50;

    logic               Clock;
    logic               Reset;
    logic               Change;
    logic [MONEY_W-1:0] Money;
    logic               Coin_Ack;
    logic               Coin_Out;
    logic               Busy;
    logic [MONEY_W-1:0] Remaining;
    logic               Done;
    logic               Fault;

    int checks   = 0;
    int failures = 0;

    change_dispenser #(
        .MONEY_W     (MONEY_W),
        .GAP_CYC     (GAP_CYC),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Change    (Change),
        .Money     (Money),
        .Coin_Ack  (Coin_Ack),
        .Coin_Out  (Coin_Out),
        .Busy      (Busy),
        .Remaining (Remaining),
        .Done      (Done),
        .Fault     (Fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_coin"}, 32'(Coin_Out), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_rem"}, 32'(Remaining), 0);
        chk({tag, "_done"}, 32'(Done), 0);
        chk({tag, "_fault"}, 32'(Fault), 0);
    endtask

    // Entered on the first EJECT cycle of coin i (i = Remaining).
    // Acks on the second EJECT cycle, then walks the gap or the Done cycle.
    // poke injects a Change with Money=7 during the gap, which must be ignored.
    task automatic pay_coin(input int i, input bit poke);
        chk("coin_rise", 32'(Coin_Out), 1);
        chk("coin_rem", 32'(Remaining), 32'(i));
        chk("coin_busy", 32'(Busy), 1);
        tick();
        chk("coin_hold", 32'(Coin_Out), 1);
        Coin_Ack = 1'b1;
        tick();
        Coin_Ack = 1'b0;
        chk("ack_coin_low", 32'(Coin_Out), 0);
        chk("ack_rem_dec", 32'(Remaining), 32'(i - 1));
        if (i > 1) begin
            chk("gap1_done", 32'(Done), 0);
            if (poke) begin
                Change = 1'b1;
                Money  = 5'd7;
            end
            tick();
            Change = 1'b0;
            chk("gap2_coin", 32'(Coin_Out), 0);
            chk("gap2_rem", 32'(Remaining), 32'(i - 1));
            tick();
            chk("gap3_coin", 32'(Coin_Out), 0);
            tick();
        end else begin
            chk("done_pulse", 32'(Done), 1);
            chk("done_busy", 32'(Busy), 1);
            tick();
            chk("post_done_done", 32'(Done), 0);
            chk("post_done_busy", 32'(Busy), 0);
            chk("post_done_rem", 32'(Remaining), 0);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        Change   = 1'b1;
        Money    = 5'd5;
        Coin_Ack = 1'b1;

        // T1: reset dominates Change and Coin_Ack
        tick();
        tick();
        chk_idle("t1_reset");
        Reset    = 1'b0;
        Change   = 1'b0;
        Coin_Ack = 1'b0;
        tick();
        chk_idle("t1_idle");

        // T2: normal payout of 3 coins
        Money  = 5'd3;
        Change = 1'b1;
        tick();
        Change = 1'b0;
        Money  = 5'd0;
        for (int i = 3; i >= 1; i--) begin
            pay_coin(i, 1'b0);
        end

        // T3: zero balance goes straight to Done
        Money  = 5'd0;
        Change = 1'b1;
        tick();
        Change = 1'b0;
        chk("t3_done", 32'(Done), 1);
        chk("t3_busy", 32'(Busy), 1);
        chk("t3_coin", 32'(Coin_Out), 0);
        tick();
        chk_idle("t3_after");

        // T4: first coin acked, second times out, then retry
        Money  = 5'd2;
        Change = 1'b1;
        tick();
        Change = 1'b0;
        pay_coin(2, 1'b0);
        chk("t4_rise2", 32'(Coin_Out), 1);
        for (int j = 1; j < ACK_TIMEOUT; j++) begin
            tick();
            chk("t4_wait_coin", 32'(Coin_Out), 1);
            chk("t4_wait_fault", 32'(Fault), 0);
        end
        tick();
        chk("t4_fault", 32'(Fault), 1);
        chk("t4_fault_coin", 32'(Coin_Out), 0);
        chk("t4_fault_rem", 32'(Remaining), 1);
        chk("t4_fault_busy", 32'(Busy), 1);
        tick();
        tick();
        chk("t4_fault_sticky", 32'(Fault), 1);
        Money  = 5'd9;
        Change = 1'b1;
        tick();
        Change = 1'b0;
        chk("t4_retry_fault", 32'(Fault), 0);
        pay_coin(1, 1'b0);

        // T5a: Change mid-payout is ignored
        Money  = 5'd3;
        Change = 1'b1;
        tick();
        Change = 1'b0;
        pay_coin(3, 1'b1);
        pay_coin(2, 1'b1);
        pay_coin(1, 1'b0);

        // T5b: Coin_Ack held high, one coin per 1+GAP_CYC cycles
        Coin_Ack = 1'b1;
        Money    = 5'd4;
        Change   = 1'b1;
        tick();
        Change = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_eject", 32'(Coin_Out), 1);
            chk("t5_rem", 32'(Remaining), 32'(4 - k));
            tick();
            if (k < 3) begin
                chk("t5_gap_rem", 32'(Remaining), 32'(3 - k));
                for (int g = 0; g < GAP_CYC; g++) begin
                    chk("t5_gap_coin", 32'(Coin_Out), 0);
                    tick();
                end
            end else begin
                chk("t5_done", 32'(Done), 1);
                chk("t5_done_rem", 32'(Remaining), 0);
            end
        end
        tick();
        chk_idle("t5_after");
        Coin_Ack = 1'b0;
        tick();
        chk_idle("t5_idle");

        // T6: reset during GAP with Remaining=2
        Money  = 5'd3;
        Change = 1'b1;
        tick();
        Change = 1'b0;
        chk("t6_rise", 32'(Coin_Out), 1);
        tick();
        Coin_Ack = 1'b1;
        tick();
        Coin_Ack = 1'b0;
        chk("t6_gap_rem", 32'(Remaining), 2);
        chk("t6_gap_coin", 32'(Coin_Out), 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_idle("t6_reset");
        for (int j = 0; j < GAP_CYC + 2; j++) begin
            tick();
            chk("t6_no_done", 32'(Done), 0);
            chk("t6_no_coin", 32'(Coin_Out), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
